// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined segment adder: stage-count derivation
// and the width check used at elaboration.
package adder_pkg;

  // Number of SEG-bit segments (one pipeline stage each) in an N-bit add.
  function automatic int calc_stages(input int n, input int seg);
    return n / seg;
  endfunction

  // True when N splits evenly into at least one SEG-bit segment.
  function automatic bit widths_ok(input int n, input int seg);
    return (seg > 0) && (n >= seg) && ((n % seg) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit combinational ripple-carry slice. Besides the carry out it exposes
// the carry into its MSB so the top-level slice can form signed overflow.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[SEG];
  assign cm = c[SEG-1];

endmodule

// File: rtl/pipelined_segment_adder.sv
// Pipelined N-bit add/subtract: one SEG-bit ripple segment per stage, carry
// registered between stages, valid/ready on both sides.
//
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high. A producer holds valid and its data stable until
// that edge; ready may depend combinationally on the downstream ready, but
// valid never depends on ready, so there is no in_valid -> out_valid path.
module pipelined_segment_adder
  import adder_pkg::*;
#(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int STAGES = calc_stages(N, SEG);

  if (!widths_ok(N, SEG)) begin : g_bad_widths
    $error("pipelined_segment_adder: N must be a non-zero multiple of SEG");
  end

  // Per-stage state: valid, operands still to be consumed by later stages
  // (b already inverted for subtract), partial sum, carry out and carry into
  // the segment MSB.
  logic [STAGES-1:0] v_q, v_d;
  logic [N-1:0]      a_q   [STAGES];
  logic [N-1:0]      a_d   [STAGES];
  logic [N-1:0]      b_q   [STAGES];
  logic [N-1:0]      b_d   [STAGES];
  logic [N-1:0]      sum_q [STAGES];
  logic [N-1:0]      sum_d [STAGES];
  logic [STAGES-1:0] c_q, c_d;
  logic [STAGES-1:0] cm_q, cm_d;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] en;

  logic [N-1:0]      b_eff;
  logic [SEG-1:0]    seg_a [STAGES];
  logic [SEG-1:0]    seg_b [STAGES];
  logic [SEG-1:0]    seg_s [STAGES];
  logic [STAGES-1:0] seg_ci;
  logic [STAGES-1:0] seg_co;
  logic [STAGES-1:0] seg_cm;

  // Subtract is a + ~b + !cin: invert b up front and flip the carry-in.
  assign b_eff = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign seg_a[k]  = a[SEG-1:0];
      assign seg_b[k]  = b_eff[SEG-1:0];
      assign seg_ci[k] = cin ^ sub;
    end else begin : g_next
      assign seg_a[k]  = a_q[k-1][k*SEG +: SEG];
      assign seg_b[k]  = b_q[k-1][k*SEG +: SEG];
      assign seg_ci[k] = c_q[k-1];
    end

    adder_segment #(.SEG(SEG)) u_seg (
      .a  (seg_a[k]),
      .b  (seg_b[k]),
      .ci (seg_ci[k]),
      .s  (seg_s[k]),
      .co (seg_co[k]),
      .cm (seg_cm[k])
    );
  end

  // Backpressure chain: a stage advances when its successor is empty or
  // advancing; a stage may load when it is empty or advancing.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = v_q[STAGES-1] & out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
    end
    en = ~v_q | adv;
  end

  // Next-state for every stage: shift the beat forward and fill in its segment.
  always_comb begin
    v_d  = v_q;
    c_d  = c_q;
    cm_d = cm_q;
    for (int k = 0; k < STAGES; k++) begin
      a_d[k]   = a_q[k];
      b_d[k]   = b_q[k];
      sum_d[k] = sum_q[k];
    end

    if (en[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        a_d[0]            = a;
        b_d[0]            = b_eff;
        sum_d[0]          = '0;
        sum_d[0][SEG-1:0] = seg_s[0];
        c_d[0]            = seg_co[0];
        cm_d[0]           = seg_cm[0];
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (en[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          a_d[k]              = a_q[k-1];
          b_d[k]              = b_q[k-1];
          sum_d[k]            = sum_q[k-1];
          sum_d[k][k*SEG +: SEG] = seg_s[k];
          c_d[k]              = seg_co[k];
          cm_d[k]             = seg_cm[k];
        end
      end
    end
  end

  // Pipeline registers; reset discards every in-flight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q  <= '0;
      c_q  <= '0;
      cm_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      v_q  <= v_d;
      c_q  <= c_d;
      cm_q <= cm_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = sum_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = cm_q[STAGES-1] ^ c_q[STAGES-1];

endmodule
